// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one psram controller among several clients.
// One command is in flight at a time; read data is routed back to its owner.
module psram_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int ADDRESS_BITS = 23,
  parameter int DATA_BITS    = 16,
  parameter int RD_LATENCY   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            we,
  input  logic [NUM_CLIENTS*ADDRESS_BITS-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0]  wdata,
  output logic [NUM_CLIENTS-1:0]            gnt,
  output logic [DATA_BITS-1:0]              rdata,
  output logic [NUM_CLIENTS-1:0]            rdata_valid,
  output logic [ADDRESS_BITS-1:0]           psram_rd_address,
  output logic                              psram_rd_en,
  input  logic                              psram_rd_ack,
  input  logic [DATA_BITS-1:0]              psram_rd_data,
  output logic [ADDRESS_BITS-1:0]           psram_wr_address,
  output logic                              psram_wr_en,
  output logic [DATA_BITS-1:0]              psram_wr_data,
  input  logic                              psram_wr_ack
);

  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int LW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t                  state;
  logic [CW-1:0]           ptr;
  logic [CW-1:0]           owner;
  logic [LW-1:0]           cnt;
  logic                    cmd_we;
  logic [ADDRESS_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0]    cmd_wdata;

  logic                    found;
  logic [CW-1:0]           win;
  logic [CW-1:0]           idx;
  logic                    sel_we;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0]    sel_wdata;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx = CW'((int'(ptr) + k) % NUM_CLIENTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (CW'(i) == win) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDRESS_BITS +: ADDRESS_BITS];
        sel_wdata = wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign psram_rd_address = cmd_addr;
  assign psram_wr_address = cmd_addr;
  assign psram_wr_data    = cmd_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= CW'(NUM_CLIENTS - 1);
      owner       <= '0;
      cnt         <= '0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      gnt         <= '0;
      rdata       <= '0;
      rdata_valid <= '0;
      psram_rd_en <= 1'b0;
      psram_wr_en <= 1'b0;
    end else begin
      gnt         <= '0;
      rdata_valid <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner       <= win;
            ptr         <= win;
            cmd_we      <= sel_we;
            cmd_addr    <= sel_addr;
            cmd_wdata   <= sel_wdata;
            gnt         <= NUM_CLIENTS'(1) << win;
            psram_rd_en <= ~sel_we;
            psram_wr_en <= sel_we;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we && psram_wr_ack) begin
            psram_wr_en <= 1'b0;
            state       <= IDLE;
          end else if (!cmd_we && psram_rd_ack) begin
            psram_rd_en <= 1'b0;
            cnt         <= LW'(1);
            state       <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (cnt == LW'(RD_LATENCY)) begin
            rdata       <= psram_rd_data;
            rdata_valid <= NUM_CLIENTS'(1) << owner;
            state       <= IDLE;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed scenarios plus random traffic
// against a psram controller model and a round-robin reference.
module tb_psram_arbiter;

  localparam int N  = 4;
  localparam int AB = 23;
  localparam int DB = 16;
  localparam int L  = 3;
  localparam int NOPS = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  we = '0;
  logic [AB-1:0] c_addr [N];
  logic [DB-1:0] c_wdata [N];
  logic [N*AB-1:0] addr_bus;
  logic [N*DB-1:0] wdata_bus;
  logic [N-1:0]  gnt;
  logic [DB-1:0] rdata;
  logic [N-1:0]  rdata_valid;
  logic [AB-1:0] psram_rd_address;
  logic          psram_rd_en;
  logic          psram_rd_ack = 1'b0;
  logic [DB-1:0] psram_rd_data = '0;
  logic [AB-1:0] psram_wr_address;
  logic          psram_wr_en;
  logic [DB-1:0] psram_wr_data;
  logic          psram_wr_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AB +: AB]  = c_addr[i];
      wdata_bus[i*DB +: DB] = c_wdata[i];
    end
  end

  psram_arbiter #(
    .NUM_CLIENTS(N), .ADDRESS_BITS(AB),
    .DATA_BITS(DB), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .we(we),
    .addr(addr_bus), .wdata(wdata_bus),
    .gnt(gnt), .rdata(rdata),
    .rdata_valid(rdata_valid),
    .psram_rd_address(psram_rd_address),
    .psram_rd_en(psram_rd_en),
    .psram_rd_ack(psram_rd_ack),
    .psram_rd_data(psram_rd_data),
    .psram_wr_address(psram_wr_address),
    .psram_wr_en(psram_wr_en),
    .psram_wr_data(psram_wr_data),
    .psram_wr_ack(psram_wr_ack)
  );

  // psram controller model: acks at negedge, data returned L cycles after ack
  int cyc = 0;
  int ack_mode = 0;
  int rd_run = 0;
  int wr_run = 0;
  int rd_hs_n = 0;
  int wr_hs_n = 0;
  int rd_hs_cyc = 0;
  logic [AB-1:0] rd_hs_addr = '0;
  logic [AB-1:0] wr_hs_addr = '0;
  logic [DB-1:0] wr_hs_data = '0;
  logic [DB-1:0] mem [int];
  bit            pv [16];
  logic [DB-1:0] pd [16];

  always @(negedge clk) begin
    int s;
    cyc++;
    psram_rd_data = pv[cyc % 16] ? pd[cyc % 16] : DB'($urandom);
    pv[cyc % 16] = 1'b0;
    rd_run = psram_rd_en ? rd_run + 1 : 0;
    wr_run = psram_wr_en ? wr_run + 1 : 0;
    case (ack_mode)
      0: begin
        psram_rd_ack = psram_rd_en;
        psram_wr_ack = psram_wr_en;
      end
      1: begin
        psram_rd_ack = psram_rd_en && rd_run >= 3;
        psram_wr_ack = psram_wr_en && wr_run >= 3;
      end
      default: begin
        psram_rd_ack = psram_rd_en ? ($urandom % 3 != 0) : ($urandom % 5 == 0);
        psram_wr_ack = psram_wr_en ? ($urandom % 3 != 0) : ($urandom % 5 == 0);
      end
    endcase
    if (psram_rd_en && psram_rd_ack) begin
      rd_hs_n++;
      rd_hs_cyc  = cyc;
      rd_hs_addr = psram_rd_address;
      s = (cyc + L) % 16;
      pv[s] = 1'b1;
      pd[s] = mem.exists(int'(psram_rd_address)) ? mem[int'(psram_rd_address)] : '0;
    end
    if (psram_wr_en && psram_wr_ack) begin
      wr_hs_n++;
      wr_hs_addr = psram_wr_address;
      wr_hs_data = psram_wr_data;
      mem[int'(psram_wr_address)] = psram_wr_data;
    end
  end

  task automatic issue(input int c, input bit w, input logic [AB-1:0] a,
                       input logic [DB-1:0] d, output logic [N-1:0] gv);
    gv = '0;
    we[c] = w;
    c_addr[c] = a;
    c_wdata[c] = d;
    req[c] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin
        gv = gnt;
        break;
      end
    end
    req[c] = 1'b0;
  endtask

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (gnt !== '0) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    tests++;
    if (rdata_valid !== '0) begin fails++; $display("FAIL reset_rvalid got %b want 0000", rdata_valid); end
    tests++;
    if (rdata !== '0) begin fails++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    tests++;
    if (psram_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %b want 0", psram_rd_en); end
    tests++;
    if (psram_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", psram_wr_en); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    logic [N-1:0] gv;
    int n0;
    bit held, seen;
    ack_mode = 1;
    n0 = wr_hs_n;
    issue(1, 1'b1, 23'h000123, 16'hBEEF, gv);
    tests++;
    if (gv !== 4'b0010) begin fails++; $display("FAIL write_gnt got %b want 0010", gv); end
    tests++;
    if (psram_wr_en !== 1'b1 || psram_rd_en !== 1'b0 ||
        psram_wr_address !== 23'h000123 || psram_wr_data !== 16'hBEEF) begin
      fails++;
      $display("FAIL write_issue got wr_en=%b rd_en=%b a=%h d=%h want 1 0 000123 beef",
               psram_wr_en, psram_rd_en, psram_wr_address, psram_wr_data);
    end
    held = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (wr_hs_n != n0) begin seen = 1'b1; break; end
      if (psram_wr_en !== 1'b1 || gnt !== '0) held = 1'b0;
    end
    tests++;
    if (!seen || !held) begin fails++; $display("FAIL write_hold got seen=%b held=%b want 1 1", seen, held); end
    tests++;
    if (psram_wr_en !== 1'b0 || wr_hs_addr !== 23'h000123 || wr_hs_data !== 16'hBEEF) begin
      fails++;
      $display("FAIL write_done got wr_en=%b a=%h d=%h want 0 000123 beef",
               psram_wr_en, wr_hs_addr, wr_hs_data);
    end
  endtask

  task automatic test_readback();
    logic [N-1:0] gv, vv;
    logic [DB-1:0] vd;
    int n0, t, vc;
    ack_mode = 1;
    n0 = rd_hs_n;
    issue(1, 1'b0, 23'h000123, 16'h0, gv);
    tests++;
    if (gv !== 4'b0010 || psram_rd_en !== 1'b1 || psram_wr_en !== 1'b0 ||
        psram_rd_address !== 23'h000123) begin
      fails++;
      $display("FAIL read_issue got gnt=%b rd_en=%b wr_en=%b a=%h want 0010 1 0 000123",
               gv, psram_rd_en, psram_wr_en, psram_rd_address);
    end
    for (int k = 0; k < 20 && rd_hs_n == n0; k++) begin
      @(posedge clk); #1;
    end
    t = rd_hs_cyc;
    vc = -1;
    vv = '0;
    vd = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rdata_valid != '0) begin
        vc = cyc + 1;
        vv = rdata_valid;
        vd = rdata;
        break;
      end
    end
    tests++;
    if (vc != t + L + 1) begin fails++; $display("FAIL read_latency got cycle %0d want %0d", vc, t + L + 1); end
    tests++;
    if (vv !== 4'b0010 || vd !== 16'hBEEF) begin
      fails++;
      $display("FAIL read_data got valid=%b data=%h want 0010 beef", vv, vd);
    end
    @(posedge clk); #1;
    tests++;
    if (rdata_valid !== '0 || rdata !== 16'hBEEF) begin
      fails++;
      $display("FAIL read_hold got valid=%b data=%h want 0000 beef", rdata_valid, rdata);
    end
  endtask

  task automatic test_fairness();
    int g [9];
    int n;
    ack_mode = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      we[i] = 1'b1;
      c_addr[i] = AB'(23'h000100 + i);
      c_wdata[i] = DB'(16'hA000 + i);
    end
    req = 4'b1111;
    n = 0;
    for (int k = 0; k < 200 && n < 9; k++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin
        g[n] = -1;
        for (int i = 0; i < N; i++) if (gnt == (4'(1) << i)) g[n] = i;
        n++;
        if (n == 6) req = 4'b0100;
      end
    end
    req = '0;
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (i >= n || g[i] != ((i < 6) ? i % 4 : 2)) begin
        fails++;
        $display("FAIL fair_grant%0d got %0d want %0d", i, (i < n) ? g[i] : -1, (i < 6) ? i % 4 : 2);
      end
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_bank();
    logic [N-1:0] gv;
    int n0;
    bit seen;
    ack_mode = 2;
    n0 = wr_hs_n;
    issue(3, 1'b1, 23'h7FFFFF, 16'h1234, gv);
    tests++;
    if (gv !== 4'b1000 || psram_wr_address !== 23'h7FFFFF) begin
      fails++;
      $display("FAIL bank_wr got gnt=%b a=%h want 1000 7fffff", gv, psram_wr_address);
    end
    for (int k = 0; k < 40 && wr_hs_n == n0; k++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (wr_hs_n == n0 || wr_hs_addr !== 23'h7FFFFF || wr_hs_data !== 16'h1234) begin
      fails++;
      $display("FAIL bank_wr_done got a=%h d=%h want 7fffff 1234", wr_hs_addr, wr_hs_data);
    end
    issue(3, 1'b0, 23'h7FFFFF, 16'h0, gv);
    tests++;
    if (gv !== 4'b1000 || psram_rd_address !== 23'h7FFFFF) begin
      fails++;
      $display("FAIL bank_rd got gnt=%b a=%h want 1000 7fffff", gv, psram_rd_address);
    end
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (rdata_valid != '0) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || rdata_valid !== 4'b1000 || rdata !== 16'h1234) begin
      fails++;
      $display("FAIL bank_rdata got valid=%b data=%h want 1000 1234", rdata_valid, rdata);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_wait_rd();
    logic [N-1:0] gv;
    int n0;
    bit quiet, seen;
    ack_mode = 0;
    n0 = rd_hs_n;
    issue(2, 1'b0, 23'h000200, 16'h0, gv);
    for (int k = 0; k < 20 && rd_hs_n == n0; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rdata_valid !== '0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin fails++; $display("FAIL rst_discard got stray rdata_valid want none"); end
    we[0] = 1'b0; c_addr[0] = 23'h000123;
    we[3] = 1'b1; c_addr[3] = 23'h000300; c_wdata[3] = 16'h5555;
    req = 4'b1001;
    gv = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin gv = gnt; break; end
    end
    req[0] = 1'b0;
    tests++;
    if (gv !== 4'b0001) begin fails++; $display("FAIL rst_first_gnt got %b want 0001", gv); end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rdata_valid != '0) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || rdata_valid !== 4'b0001 || rdata !== 16'hBEEF) begin
      fails++;
      $display("FAIL rst_read got valid=%b data=%h want 0001 beef", rdata_valid, rdata);
    end
    gv = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin gv = gnt; break; end
    end
    req = '0;
    tests++;
    if (gv !== 4'b1000) begin fails++; $display("FAIL rst_second_gnt got %b want 1000", gv); end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [DB-1:0] ref_mem [int];
    logic [N-1:0] pend, req_dec;
    logic [AB-1:0] o_addr;
    logic [DB-1:0] o_exp, o_wd;
    bit busy, busy_rd, rd_acked, o_we, found;
    int last, own, w, j, t_ack, rdn0, wrn0;
    int ops, reads_g, reads_v, guard;
    ack_mode = 2;
    do_reset();
    pend = '0;
    last = N - 1;
    busy = 0; busy_rd = 0; rd_acked = 0;
    own = 0; t_ack = 0; o_addr = '0; o_exp = '0; o_wd = '0; o_we = 0;
    ops = 0; reads_g = 0; reads_v = 0; guard = 0;
    rdn0 = rd_hs_n;
    wrn0 = wr_hs_n;
    while ((ops < NOPS || busy || pend != '0) && guard < 60000) begin
      req_dec = req;
      @(posedge clk); #1;
      guard++;
      tests++;
      if (psram_rd_en && psram_wr_en) begin fails++; $display("FAIL rnd_both_en at cycle %0d", cyc + 1); end
      if (wr_hs_n != wrn0) begin
        wrn0 = wr_hs_n;
        tests++;
        if (!busy || busy_rd || wr_hs_addr !== o_addr || wr_hs_data !== o_wd) begin
          fails++;
          $display("FAIL rnd_write got a=%h d=%h want %h %h busy=%b rd=%b",
                   wr_hs_addr, wr_hs_data, o_addr, o_wd, busy, busy_rd);
        end
        busy = 0;
      end
      if (rd_hs_n != rdn0) begin
        rdn0 = rd_hs_n;
        tests++;
        if (!busy || !busy_rd || rd_acked || rd_hs_addr !== o_addr) begin
          fails++;
          $display("FAIL rnd_read_ack got a=%h want %h busy=%b rd=%b", rd_hs_addr, o_addr, busy, busy_rd);
        end
        rd_acked = 1;
        t_ack = rd_hs_cyc;
      end
      if (rdata_valid != '0) begin
        reads_v++;
        tests++;
        if (!(busy && busy_rd && rd_acked) || rdata_valid !== (4'(1) << own) ||
            rdata !== o_exp || cyc + 1 != t_ack + L + 1) begin
          fails++;
          $display("FAIL rnd_rdata got valid=%b data=%h cyc=%0d want %b %h %0d",
                   rdata_valid, rdata, cyc + 1, 4'(1) << own, o_exp, t_ack + L + 1);
        end
        busy = 0;
        rd_acked = 0;
      end else if (busy && busy_rd && rd_acked && cyc + 1 > t_ack + L + 1) begin
        tests++;
        fails++;
        $display("FAIL rnd_rdata_missing got none want valid at %0d", t_ack + L + 1);
        busy = 0;
        rd_acked = 0;
      end
      if (gnt != '0) begin
        found = 0;
        w = 0;
        for (int k = 1; k <= N; k++) begin
          j = (last + k) % N;
          if (!found && req_dec[j]) begin found = 1; w = j; end
        end
        tests++;
        if (busy || !found || gnt !== (4'(1) << w)) begin
          fails++;
          $display("FAIL rnd_gnt got %b want %b busy=%b", gnt, 4'(1) << w, busy);
        end
        last = w;
        own = w;
        o_we = we[w];
        o_addr = c_addr[w];
        o_wd = c_wdata[w];
        if (o_we) ref_mem[int'(o_addr)] = o_wd;
        else o_exp = ref_mem.exists(int'(o_addr)) ? ref_mem[int'(o_addr)] : '0;
        busy = 1;
        busy_rd = !o_we;
        rd_acked = 0;
        ops++;
        if (!o_we) reads_g++;
        pend[w] = 1'b0;
        req[w] = 1'b0;
      end
      if (ops < NOPS) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom % 3 == 0) begin
            pend[i] = 1'b1;
            we[i] = 1'($urandom % 2);
            c_addr[i] = 23'h400000 | AB'($urandom_range(0, 15));
            c_wdata[i] = DB'($urandom);
            req[i] = 1'b1;
          end
        end
      end
    end
    req = '0;
    tests++;
    if (guard >= 60000) begin fails++; $display("FAIL rnd_timeout got %0d ops want %0d", ops, NOPS); end
    tests++;
    if (reads_v != reads_g) begin fails++; $display("FAIL rnd_read_count got %0d want %0d", reads_v, reads_g); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      c_addr[i] = '0;
      c_wdata[i] = '0;
    end
    test_reset();
    test_write();
    test_readback();
    test_fairness();
    test_bank();
    test_reset_wait_rd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
